// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-memory responder: FSM state encodings and the
// CPU opcodes that generate data-strobe cycles.
package data_mem_resp_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RWAIT  = 3'd1;
  localparam logic [2:0] RDRIVE = 3'd2;
  localparam logic [2:0] WWAIT  = 3'd3;
  localparam logic [2:0] WDONE  = 3'd4;

  localparam logic [4:0] OP_STA = 5'b01100;
  localparam logic [4:0] OP_LDA = 5'b01110;

endpackage

// File: rtl/data_mem_resp_ram.sv
// Single-port synchronous data RAM with registered read data (one-cycle read).
module dmem_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory-side responder for the CPU data strobes nDRD/nDWR: latches the access on
// the strobe falling edge, waits WAIT_CYCLES, then drives read data or commits the write.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nDRD,
  input  logic          nDWR,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          doe,
  output logic          rdy,
  output logic          err
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [2:0]    state;
  logic [3:0]    cnt;
  logic          prevRd, prevWr, armed;
  logic [AW-1:0] addrQ;
  logic [DW-1:0] dinQ;
  logic          rdFall, wrFall;
  logic          ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramRdata;

  // armed masks the first cycle after reset so a strobe held low through reset
  // is never seen as a falling edge against the reset-high history.
  assign rdFall = armed & prevRd & ~nDRD;
  assign wrFall = armed & prevWr & ~nDWR;

  // In IDLE the RAM reads the live address so a zero-wait read has its data
  // ready on the very next edge; afterwards it follows the latched address.
  always_comb begin
    ramWe   = rst && (state == WWAIT) && (cnt == '0);
    ramAddr = (state == IDLE) ? addr : addrQ;
  end

  dmem_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(dinQ),
    .rdata(ramRdata)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && !(!nDRD && !nDWR) && (rdFall || wrFall)) begin
      addrQ <= addr;
      if (!rdFall) dinQ <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prevRd <= 1'b1;
      prevWr <= 1'b1;
      armed  <= 1'b0;
      dout   <= '0;
      doe    <= 1'b0;
      rdy    <= 1'b0;
      err    <= 1'b0;
    end else begin
      prevRd <= nDRD;
      prevWr <= nDWR;
      armed  <= 1'b1;
      case (state)
        IDLE: begin
          if (!nDRD && !nDWR) begin
            err <= 1'b1;
          end else if (rdFall) begin
            cnt   <= CNT_INIT;
            state <= RWAIT;
          end else if (wrFall) begin
            cnt   <= CNT_INIT;
            state <= WWAIT;
          end
        end
        RWAIT: begin
          if (wrFall) err <= 1'b1;
          if (nDRD) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            dout  <= ramRdata;
            doe   <= 1'b1;
            rdy   <= 1'b1;
            state <= RDRIVE;
          end
        end
        RDRIVE: begin
          if (wrFall) err <= 1'b1;
          if (nDRD) begin
            doe   <= 1'b0;
            rdy   <= 1'b0;
            state <= IDLE;
          end
        end
        WWAIT: begin
          if (rdFall) err <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdy   <= 1'b1;
            state <= WDONE;
          end
        end
        WDONE: begin
          if (rdFall) err <= 1'b1;
          if (nDWR) begin
            rdy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench: three responders (WAIT_CYCLES 1, 0, 3) share one stimulus
// stream; per-instance monitors check every rdy rise against a queued expectation.
`timescale 1ns/1ps
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  localparam int ND = 3;

  function automatic int wcOf(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  typedef struct packed {
    logic [4:0]  op;
    logic [7:0]  a;
    logic [7:0]  d;
    int unsigned issue;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nDRD = 1'b1;
  logic       nDWR = 1'b1;
  logic [7:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout [ND];
  logic       doe [ND];
  logic       rdy [ND];
  logic       err [ND];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq [ND][$];
  logic [7:0]  refMem [256];
  bit          written [256];
  logic [7:0]  wlist [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  for (genvar g = 0; g < ND; g++) begin : duts
    data_mem_resp #(.AW(8), .DW(8), .WAIT_CYCLES(wcOf(g))) dut (
      .clk (clk),
      .rst (rst),
      .nDRD(nDRD),
      .nDWR(nDWR),
      .addr(addr),
      .din (din),
      .dout(dout[g]),
      .doe (doe[g]),
      .rdy (rdy[g]),
      .err (err[g])
    );

    logic rdyPrev = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      if (rdy[g] === 1'b1 && rdyPrev !== 1'b1) begin
        if (sbq[g].size() == 0) begin
          chk($sformatf("unexpected_rdy_dut%0d", g), 32'(rdy[g]), 32'd0);
        end else begin
          e = sbq[g].pop_front();
          chk($sformatf("latency_dut%0d", g), cyc - e.issue, 32'(wcOf(g) + 1));
          if (e.op == OP_LDA) begin
            chk($sformatf("read_doe_dut%0d_a%0h", g, e.a), 32'(doe[g]), 32'd1);
            chk($sformatf("read_dout_dut%0d_a%0h", g, e.a), 32'(dout[g]), 32'(e.d));
          end else begin
            chk($sformatf("write_doe_dut%0d_a%0h", g, e.a), 32'(doe[g]), 32'd0);
          end
        end
      end
      if (doe[g] === 1'b1) chk($sformatf("doe_without_rdy_dut%0d", g), 32'(rdy[g]), 32'd1);
      rdyPrev = rdy[g];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_doe_dut%0d", tag, d), 32'(doe[d]), 32'd0);
      chk($sformatf("%s_rdy_dut%0d", tag, d), 32'(rdy[d]), 32'd0);
    end
  endtask

  task automatic applyReset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_dout_dut%0d", d), 32'(dout[d]), 32'd0);
      chk($sformatf("reset_err_dut%0d", d), 32'(err[d]), 32'd0);
    end
    checkIdleOutputs("reset");
    rst = 1'b1;
    idle(2);
  endtask

  // A read completes on instances whose wait fits inside the low window
  // (falling-edge sample plus WAIT_CYCLES+1 further low samples); others abort.
  task automatic doRead(input logic [7:0] a, input int lowCycles, input int pokeAt);
    exp_t e;
    bit   done [ND];
    e.op    = OP_LDA;
    e.a     = a;
    e.d     = refMem[a];
    e.issue = cyc + 1;
    addr = a;
    nDRD = 1'b0;
    for (int d = 0; d < ND; d++) begin
      done[d] = (lowCycles >= wcOf(d) + 2);
      if (done[d]) sbq[d].push_back(e);
    end
    for (int i = 1; i <= lowCycles; i++) begin
      @(negedge clk);
      if (i == 1) addr = 8'($urandom);
      if (pokeAt > 0 && i == pokeAt) nDWR = 1'b0;
      if (pokeAt > 0 && i == pokeAt + 1) nDWR = 1'b1;
    end
    nDRD = 1'b1;
    @(negedge clk);
    checkIdleOutputs("read_release");
    for (int d = 0; d < ND; d++)
      if (done[d]) chk($sformatf("dout_hold_dut%0d", d), 32'(dout[d]), 32'(e.d));
    idle(3);
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] dv, input int lowCycles);
    exp_t e;
    e.op    = OP_STA;
    e.a     = a;
    e.d     = dv;
    e.issue = cyc + 1;
    addr = a;
    din  = dv;
    nDWR = 1'b0;
    for (int d = 0; d < ND; d++) sbq[d].push_back(e);
    if (!written[a]) begin
      written[a] = 1'b1;
      wlist.push_back(a);
    end
    refMem[a] = dv;
    for (int i = 1; i <= lowCycles; i++) begin
      @(negedge clk);
      if (i == 1) begin
        addr = 8'($urandom);
        din  = 8'($urandom);
      end
    end
    nDWR = 1'b1;
    idle(7);
  endtask

  initial begin
    logic [7:0] ra;
    @(negedge clk);
    applyReset(2);

    doWrite(8'h10, 8'hA5, 4);
    doRead(8'h10, 6, 0);
    doWrite(8'hFF, 8'h3C, 2);
    doRead(8'hFF, 5, 0);

    doRead(8'h10, 2, 0);
    doWrite(8'h20, 8'h5A, 1);
    doRead(8'h20, 5, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        ra = wlist[$urandom_range(wlist.size() - 1, 0)];
        doRead(ra, int'($urandom_range(7, 1)), 0);
      end else begin
        doWrite(8'($urandom), 8'($urandom), int'($urandom_range(5, 1)));
      end
    end

    doWrite(8'h30, 8'h11, 3);
    addr = 8'h30;
    din  = 8'hEE;
    nDRD = 1'b0;
    nDWR = 1'b0;
    idle(3);
    nDRD = 1'b1;
    nDWR = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("conflict_err_dut%0d", d), 32'(err[d]), 32'd1);
    checkIdleOutputs("conflict");
    idle(4);
    doRead(8'h30, 6, 0);
    for (int d = 0; d < ND; d++) chk($sformatf("err_sticky_dut%0d", d), 32'(err[d]), 32'd1);
    applyReset(2);

    doRead(8'h10, 9, 6);
    for (int d = 0; d < ND; d++) chk($sformatf("opposite_err_dut%0d", d), 32'(err[d]), 32'd1);
    applyReset(2);

    doWrite(8'h40, 8'h77, 2);
    begin
      exp_t e;
      e.op    = OP_LDA;
      e.a     = 8'h40;
      e.d     = 8'h77;
      e.issue = cyc + 1;
      addr = 8'h40;
      nDRD = 1'b0;
      for (int d = 0; d < ND; d++) sbq[d].push_back(e);
    end
    idle(6);
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset_mid_read");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkIdleOutputs("held_low_after_reset");
    end
    nDRD = 1'b1;
    idle(2);
    doRead(8'h40, 5, 0);

    idle(10);
    for (int d = 0; d < ND; d++)
      chk($sformatf("missing_responses_dut%0d", d), 32'(sbq[d].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
